// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register for the RISC Toy core.
// Captures the decoded control bundle, operands, immediate, PC and register
// indices into EX, inserts a bubble on a load-use hazard, and honours
// flush (branch/jump kill) and hold (downstream freeze).
// Optional build macro: STALL_CNT_EN adds stall_cnt_o, a saturating count of
// hazard bubbles.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic              id_regwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_branch_i,
    input  logic              id_jump_i,
    input  logic              id_ldrstr_i,
    input  logic              id_memwrite_i,
    input  logic              id_memread_i,
    input  logic              id_alusrc_i,
    input  logic              id_regdst_i,
    input  logic [4:0]        id_aluctrl_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rdata_a_i,
    input  logic [DATA_W-1:0] id_rdata_b_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_ra_i,
    input  logic [REG_AW-1:0] id_rb_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_ra_i,
    input  logic              id_use_rb_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic              ex_ldrstr_o,
    output logic              ex_memwrite_o,
    output logic              ex_memread_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic [4:0]        ex_aluctrl_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rdata_a_o,
    output logic [DATA_W-1:0] ex_rdata_b_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_ra_o,
    output logic [REG_AW-1:0] ex_rb_o,
    output logic [REG_AW-1:0] ex_rd_o,
`ifdef STALL_CNT_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              id_stall_o
);

    logic ra_hit;
    logic rb_hit;
    logic hazard;
    logic load_bubble;
    logic load_entry;

    // Load-use detection against the entry currently in EX (r0 not special).
    always_comb begin
        ra_hit      = id_use_ra_i && (id_ra_i == ex_rd_o);
        rb_hit      = id_use_rb_i && (id_rb_i == ex_rd_o);
        hazard      = id_valid_i && ex_valid_o && ex_memread_o && ex_regwrite_o
                      && (ra_hit || rb_hit);
        id_stall_o  = (hazard || ex_hold_i) && !flush_i;
        load_bubble = flush_i || (!ex_hold_i && hazard);
        load_entry  = !flush_i && !ex_hold_i && !hazard;
    end

    // Valid and control bits: cleared by bubbles and by invalid ID slots.
    always_ff @(posedge clk) begin
        if (rst || load_bubble || (load_entry && !id_valid_i)) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_ldrstr_o   <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_alusrc_o   <= 1'b0;
            ex_regdst_o   <= 1'b0;
            ex_aluctrl_o  <= '0;
        end else if (load_entry) begin
            ex_valid_o    <= 1'b1;
            ex_regwrite_o <= id_regwrite_i;
            ex_memtoreg_o <= id_memtoreg_i;
            ex_branch_o   <= id_branch_i;
            ex_jump_o     <= id_jump_i;
            ex_ldrstr_o   <= id_ldrstr_i;
            ex_memwrite_o <= id_memwrite_i;
            ex_memread_o  <= id_memread_i;
            ex_alusrc_o   <= id_alusrc_i;
            ex_regdst_o   <= id_regdst_i;
            ex_aluctrl_o  <= id_aluctrl_i;
        end
    end

    // Data and index fields: loaded only on a normal transfer, held on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_pc_o      <= '0;
            ex_rdata_a_o <= '0;
            ex_rdata_b_o <= '0;
            ex_imm_o     <= '0;
            ex_ra_o      <= '0;
            ex_rb_o      <= '0;
            ex_rd_o      <= '0;
        end else if (load_entry) begin
            ex_pc_o      <= id_pc_i;
            ex_rdata_a_o <= id_rdata_a_i;
            ex_rdata_b_o <= id_rdata_b_i;
            ex_imm_o     <= id_imm_i;
            ex_ra_o      <= id_ra_i;
            ex_rb_o      <= id_rb_i;
            ex_rd_o      <= id_rd_i;
        end
    end

`ifdef STALL_CNT_EN
    // Count hazard bubbles only; flush and hold cycles are not stalls of ours.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (!flush_i && !ex_hold_i && hazard && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: a reference model predicts the EX
// entry, pushes it to a scoreboard queue, and each test pops and compares.
module tb_id_ex_pipe_reg;

    // control bit order: regwrite memtoreg branch jump ldrstr memwrite memread alusrc regdst
    typedef struct packed {
        logic        valid;
        logic [8:0]  ctl;
        logic [4:0]  alu;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
    } ex_t;

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctl;
        logic [4:0]  alu;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        use_ra;
        logic        use_rb;
    } id_t;

    localparam logic [8:0] CTL_LOAD = 9'b100000110;
    localparam logic [8:0] CTL_ALU  = 9'b100000001;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic hold;
    id_t  id;

    logic        ex_valid, ex_regwrite, ex_memtoreg, ex_branch, ex_jump;
    logic        ex_ldrstr, ex_memwrite, ex_memread, ex_alusrc, ex_regdst;
    logic [4:0]  ex_aluctrl;
    logic [31:0] ex_pc, ex_rdata_a, ex_rdata_b, ex_imm;
    logic [4:0]  ex_ra, ex_rb, ex_rd;
    logic        id_stall;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ex_t act;
    ex_t mdl;
    ex_t expv;
    ex_t held;
    ex_t sb[$];
    int  tests_run = 0;
    int  failed = 0;
    int unsigned cnt_m = 0;

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id.valid),
        .id_regwrite_i (id.ctl[8]),
        .id_memtoreg_i (id.ctl[7]),
        .id_branch_i   (id.ctl[6]),
        .id_jump_i     (id.ctl[5]),
        .id_ldrstr_i   (id.ctl[4]),
        .id_memwrite_i (id.ctl[3]),
        .id_memread_i  (id.ctl[2]),
        .id_alusrc_i   (id.ctl[1]),
        .id_regdst_i   (id.ctl[0]),
        .id_aluctrl_i  (id.alu),
        .id_pc_i       (id.pc),
        .id_rdata_a_i  (id.a),
        .id_rdata_b_i  (id.b),
        .id_imm_i      (id.imm),
        .id_ra_i       (id.ra),
        .id_rb_i       (id.rb),
        .id_rd_i       (id.rd),
        .id_use_ra_i   (id.use_ra),
        .id_use_rb_i   (id.use_rb),
        .flush_i       (flush),
        .ex_hold_i     (hold),
        .ex_valid_o    (ex_valid),
        .ex_regwrite_o (ex_regwrite),
        .ex_memtoreg_o (ex_memtoreg),
        .ex_branch_o   (ex_branch),
        .ex_jump_o     (ex_jump),
        .ex_ldrstr_o   (ex_ldrstr),
        .ex_memwrite_o (ex_memwrite),
        .ex_memread_o  (ex_memread),
        .ex_alusrc_o   (ex_alusrc),
        .ex_regdst_o   (ex_regdst),
        .ex_aluctrl_o  (ex_aluctrl),
        .ex_pc_o       (ex_pc),
        .ex_rdata_a_o  (ex_rdata_a),
        .ex_rdata_b_o  (ex_rdata_b),
        .ex_imm_o      (ex_imm),
        .ex_ra_o       (ex_ra),
        .ex_rb_o       (ex_rb),
        .ex_rd_o       (ex_rd),
`ifdef STALL_CNT_EN
        .stall_cnt_o   (stall_cnt),
`endif
        .id_stall_o    (id_stall)
    );

    always #5 clk = ~clk;

    assign act = {ex_valid,
                  ex_regwrite, ex_memtoreg, ex_branch, ex_jump, ex_ldrstr,
                  ex_memwrite, ex_memread, ex_alusrc, ex_regdst,
                  ex_aluctrl, ex_pc, ex_rdata_a, ex_rdata_b, ex_imm,
                  ex_ra, ex_rb, ex_rd};

    function automatic logic m_hazard(input ex_t m, input id_t d);
        return d.valid && m.valid && m.ctl[2] && m.ctl[8] &&
               ((d.use_ra && d.ra == m.rd) || (d.use_rb && d.rb == m.rd));
    endfunction

    function automatic logic m_stall(input ex_t m, input id_t d, input logic f, input logic h);
        return (m_hazard(m, d) || h) && !f;
    endfunction

    function automatic id_t mk(input logic v, input logic [8:0] c, input logic [4:0] al,
                               input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                               input logic ura, input logic urb);
        id_t d;
        d.valid  = v;
        d.ctl    = c;
        d.alu    = al;
        d.pc     = $urandom;
        d.a      = $urandom;
        d.b      = $urandom;
        d.imm    = $urandom;
        d.rd     = rd;
        d.ra     = ra;
        d.rb     = rb;
        d.use_ra = ura;
        d.use_rb = urb;
        return d;
    endfunction

    // Predict the next EX entry from the model state, push it, then clock.
    task automatic step();
        ex_t  nxt;
        logic hz;
        nxt = mdl;
        hz  = m_hazard(mdl, id);
        if (rst) begin
            nxt   = '0;
            cnt_m = 0;
        end else if (flush) begin
            nxt.valid = 1'b0;
            nxt.ctl   = '0;
            nxt.alu   = '0;
        end else if (hold) begin
            nxt = mdl;
        end else if (hz) begin
            nxt.valid = 1'b0;
            nxt.ctl   = '0;
            nxt.alu   = '0;
            if (cnt_m < 32'hFFFF) cnt_m++;
        end else begin
            nxt.valid = id.valid;
            nxt.ctl   = id.valid ? id.ctl : 9'd0;
            nxt.alu   = id.valid ? id.alu : 5'd0;
            nxt.pc    = id.pc;
            nxt.a     = id.a;
            nxt.b     = id.b;
            nxt.imm   = id.imm;
            nxt.ra    = id.ra;
            nxt.rb    = id.rb;
            nxt.rd    = id.rd;
        end
        sb.push_back(nxt);
        mdl = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        id    = '1;
        flush = 1'b1;
        hold  = 1'b1;
        rst   = 1'b1;
        step();
        step();
        expv = sb.pop_front();
        expv = sb.pop_front();
        tests_run++;
        if (act !== 158'd0) begin
            failed++;
            $display("FAIL reset_outputs act=%h exp=0", act);
        end
        tests_run++;
        if (id_stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_stall act=%b exp=0", id_stall);
        end
        rst = 1'b0;
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || act !== 158'd0) begin
            failed++;
            $display("FAIL reset_release act=%h exp=%h", act, expv);
        end
        flush = 1'b0;
        hold  = 1'b0;
        id    = '0;
        #1;
        tests_run++;
        if (id_stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle_stall act=%b exp=0", id_stall);
        end
    endtask

    task automatic test_load_use();
        id = mk(1'b1, CTL_LOAD, 5'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
        #1;
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv) begin
            failed++;
            $display("FAIL load_use_load act=%h exp=%h", act, expv);
        end
        id = mk(1'b1, CTL_ALU, 5'd2, 5'd5, 5'd3, 5'd7, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (id_stall !== 1'b1) begin
            failed++;
            $display("FAIL load_use_stall act=%b exp=1", id_stall);
        end
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            failed++;
            $display("FAIL load_use_bubble act=%h exp=%h", act, expv);
        end
        tests_run++;
        if (id_stall !== 1'b0) begin
            failed++;
            $display("FAIL load_use_stall_clear act=%b exp=0", id_stall);
        end
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== id.pc) begin
            failed++;
            $display("FAIL load_use_dependent act=%h exp=%h", act, expv);
        end
`ifdef STALL_CNT_EN
        tests_run++;
        if (stall_cnt !== 16'd1) begin
            failed++;
            $display("FAIL load_use_count act=%0d exp=1", stall_cnt);
        end
`endif
    endtask

    task automatic test_no_use();
        id = mk(1'b1, CTL_LOAD, 5'd1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b1) begin
            failed++;
            $display("FAIL no_use_load act=%h exp=%h", act, expv);
        end
        id = mk(1'b1, CTL_LOAD, 5'd1, 5'd6, 5'd3, 5'd7, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (id_stall !== 1'b0) begin
            failed++;
            $display("FAIL no_use_stall act=%b exp=0", id_stall);
        end
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
            failed++;
            $display("FAIL no_use_back_to_back act=%h exp=%h", act, expv);
        end
    endtask

    task automatic test_flush_hazard();
        id = mk(1'b1, CTL_LOAD, 5'd4, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        expv = sb.pop_front();
        id    = mk(1'b1, CTL_ALU, 5'd9, 5'd8, 5'd3, 5'd3, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        tests_run++;
        if (id_stall !== 1'b0) begin
            failed++;
            $display("FAIL flush_hazard_stall act=%b exp=0", id_stall);
        end
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b0 || ex_regwrite !== 1'b0 ||
            ex_memread !== 1'b0 || ex_aluctrl !== 5'd0) begin
            failed++;
            $display("FAIL flush_hazard_bubble act=%h exp=%h", act, expv);
        end
        flush = 1'b0;
    endtask

    task automatic test_hold();
        id = mk(1'b1, CTL_ALU, 5'd7, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        expv = sb.pop_front();
        held = act;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id = mk(1'b1, 9'(i + 3), 5'(i + 10), 5'(i + 11), 5'd9, 5'd9, 1'b1, 1'b1);
            #1;
            tests_run++;
            if (id_stall !== 1'b1) begin
                failed++;
                $display("FAIL hold_stall cycle=%0d act=%b exp=1", i, id_stall);
            end
            step();
            expv = sb.pop_front();
            tests_run++;
            if (act !== expv || act !== held) begin
                failed++;
                $display("FAIL hold_freeze cycle=%0d act=%h exp=%h", i, act, held);
            end
        end
        hold = 1'b0;
        id   = mk(1'b1, CTL_ALU, 5'd3, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0);
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_pc !== id.pc || ex_rd !== 5'd12 || ex_valid !== 1'b1) begin
            failed++;
            $display("FAIL hold_release act=%h exp=%h", act, expv);
        end
    endtask

    task automatic test_invalid_slot();
        id = mk(1'b0, 9'h1FF, 5'h1F, 5'd14, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        expv = sb.pop_front();
        tests_run++;
        if (act !== expv || ex_valid !== 1'b0 || ex_regwrite !== 1'b0 ||
            ex_memwrite !== 1'b0 || ex_aluctrl !== 5'd0 || ex_rd !== 5'd14) begin
            failed++;
            $display("FAIL invalid_slot act=%h exp=%h", act, expv);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            id = mk(($urandom_range(0, 9) != 0), 9'($urandom), 5'($urandom),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) id.ctl[8] = 1'b1;
            if ($urandom_range(0, 2) == 0) id.ctl[2] = 1'b1;
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            #1;
            tests_run++;
            if (id_stall !== m_stall(mdl, id, flush, hold)) begin
                failed++;
                $display("FAIL random_stall cycle=%0d act=%b exp=%b", i, id_stall,
                         m_stall(mdl, id, flush, hold));
            end
            step();
            expv = sb.pop_front();
            tests_run++;
            if (act !== expv) begin
                failed++;
                $display("FAIL random_entry cycle=%0d act=%h exp=%h", i, act, expv);
            end
`ifdef STALL_CNT_EN
            tests_run++;
            if (stall_cnt !== 16'(cnt_m)) begin
                failed++;
                $display("FAIL random_count cycle=%0d act=%0d exp=%0d", i, stall_cnt, cnt_m);
            end
`endif
        end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_saturate();
        for (int i = 0; i < 65540; i++) begin
            id = mk(1'b1, CTL_LOAD, 5'd1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
            step();
            id = mk(1'b1, CTL_ALU, 5'd2, 5'd5, 5'd3, 5'd0, 1'b1, 1'b0);
            step();
            sb.delete();
        end
        tests_run++;
        if (stall_cnt !== 16'hFFFF) begin
            failed++;
            $display("FAIL stall_saturate act=%h exp=ffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        id    = '0;
        mdl   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_use();
        test_flush_hazard();
        test_hold();
        test_invalid_slot();
        test_back_to_back();
`ifdef STALL_CNT_EN
        test_stall_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
